regfile_writeback_stage: RTL
============================

Name: regfile_writeback_stage

Overview:
- Final (WB) pipeline stage of the RV32I core and the writer side of the register file write port.
- Accepts retiring instructions from MEM/WB and selects the result: ALU result, extracted/extended load data, or PC+4.
- Drives the register file write port (addr_rd as the full instruction word, rd in [11:7]) and mirrors the same values on a forwarding port.
- Counts retired instructions, flags load errors, and halts on SYSTEM opcodes.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter (wraps modulo 2^RETIRE_W).
- HALT_ON_SYSTEM, 1, when 1 an accepted SYSTEM opcode (7'b1110011) enters HALTED.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM/WB holds a retiring instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_alu_result  in  32  ALU result / load effective address
- in_load_data  in  32  raw aligned memory word
- in_pc  in  32  instruction PC
- flush  in  1  drop the current input
- addr_rd  out  32  instruction word to register file, rd = [11:7]
- data_rd  out  32  write data
- write_enable  out  1  register file write strobe
- fwd_valid  out  1  equals write_enable
- fwd_rd  out  5  addr_rd[11:7]
- fwd_data  out  32  equals data_rd
- retire_count  out  RETIRE_W  accepted-instruction count
- load_error  out  1  sticky misaligned/illegal load flag
- halted  out  1  stage is in HALTED

Behaviour:
- Reset (async, reset_n=0): every output is 0 except in_ready; state RUN. in_ready is combinational, so it is 1 in RUN even during reset.
- FSM RUN:
  - in_ready=1.
  - Accept when in_valid && !flush at the rising edge.
  - An accepted SYSTEM opcode with HALT_ON_SYSTEM=1 moves to HALTED.
- FSM HALTED:
  - in_ready=0, halted=1, write_enable=0.
  - Exits only via reset.
- flush with in_valid: flush wins. Nothing is accepted, nothing retired, write_enable=0 next cycle.
- Latency: accepted at edge N; addr_rd/data_rd/write_enable are valid after edge N and stay valid until edge N+1.
  - write_enable is a single-cycle pulse per accepted writing instruction.
  - The register file captures at edge N+1.
  - Outputs are registered.
- No accept in a cycle: write_enable=0 next cycle. addr_rd/data_rd hold their last values.
- Result select by opcode [6:0]:
  - 0110011, 0010011, 0110111, 0010111 → in_alu_result.
  - 1101111, 1100111 → in_pc+4, wrapping mod 2^32.
  - 0000011 → load extraction.
  - 0100011, 1100011, 1110011, anything else → no write.
- rd==0: write_enable=0, regardless of opcode.
- Load extraction, off = in_alu_result[1:0], f3 = [14:12]:
  - LB (000): byte at off, sign-extended.
  - LBU (100): byte at off, zero-extended.
  - LH (001) / LHU (101): half at off[1], sign- or zero-extended. off[0]=1 is misaligned.
  - LW (010): off must be 00, otherwise misaligned.
  - f3 011/110/111: illegal.
- Misaligned or illegal load: no write, load_error set (sticky until reset), instruction still retired.
- retire_count: +1 on every accept, including non-writing and halting instructions. Wraps 2^RETIRE_W−1 → 0.
- Reset mid-operation: a pending write_enable is cleared immediately and asynchronously. No write occurs at the following edge.

Test Plan:
- Reset, then ADDI x5 (instr 32'h0050_0293, alu 32'h0000_0005) → next cycle write_enable=1, addr_rd[11:7]=5, data_rd=5, fwd_rd=5, retire_count=1.
- LB x6, off=3 (instr 32'h0000_0303, alu 32'h0000_1003, load_data 32'h80AB_CDEF) → data_rd=32'hFFFF_FF80. LBU same → 32'h0000_0080. LHU off=2 → 32'h0000_80AB.
- LW x7, alu 32'h0000_1002 → write_enable=0, load_error=1 and stays 1; retire_count increments.
- JAL x1 at in_pc 32'hFFFF_FFFC → data_rd=32'h0000_0000. ADDI to x0 → write_enable=0.
- in_valid=1 with flush=1 → write_enable=0, retire_count unchanged. Back-to-back valids for 3 cycles → three 1-cycle write pulses.
- ECALL (32'h0000_0073) → halted=1, in_ready=0, later in_valid ignored. Assert reset_n=0 mid-pulse → write_enable drops immediately and all outputs are 0.

Source files
------------

// File: rtl/regfile_writeback_stage.sv
// Writeback stage: selects the retiring result, drives the register file write port
// and its forwarding mirror, counts retirements, flags bad loads and halts on SYSTEM.
//
// state   | meaning
// RUN     | accepting retiring instructions, in_ready high
// HALTED  | SYSTEM opcode retired; nothing accepted until reset
module regfile_writeback_stage #(
  parameter int RETIRE_W       = 32,
  parameter bit HALT_ON_SYSTEM = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [31:0]         in_alu_result,
  input  logic [31:0]         in_load_data,
  input  logic [31:0]         in_pc,
  input  logic                flush,
  output logic [31:0]         addr_rd,
  output logic [31:0]         data_rd,
  output logic                write_enable,
  output logic                fwd_valid,
  output logic [4:0]          fwd_rd,
  output logic [31:0]         fwd_data,
  output logic [RETIRE_W-1:0] retire_count,
  output logic                load_error,
  output logic                halted
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {ST_RUN, ST_HALTED} state_t;
  state_t state;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        accept;
  logic        is_load;
  logic        is_system;
  logic        load_ok;
  logic        result_wr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] result;

  assign opcode    = in_instr[6:0];
  assign rd        = in_instr[11:7];
  assign f3        = in_instr[14:12];
  assign off       = in_alu_result[1:0];
  assign in_ready  = (state == ST_RUN);
  assign accept    = in_ready && in_valid && !flush;
  assign is_load   = (opcode == OPC_LOAD);
  assign is_system = (opcode == OPC_SYSTEM);

  always_comb begin
    ld_byte  = 8'h00;
    ld_half  = off[1] ? in_load_data[31:16] : in_load_data[15:0];
    load_val = 32'h0;
    load_ok  = 1'b0;
    case (off)
      2'd0:    ld_byte = in_load_data[7:0];
      2'd1:    ld_byte = in_load_data[15:8];
      2'd2:    ld_byte = in_load_data[23:16];
      default: ld_byte = in_load_data[31:24];
    endcase
    case (f3)
      3'b000: begin load_val = {{24{ld_byte[7]}}, ld_byte};  load_ok = 1'b1;     end
      3'b100: begin load_val = {24'h0, ld_byte};             load_ok = 1'b1;     end
      3'b001: begin load_val = {{16{ld_half[15]}}, ld_half}; load_ok = !off[0];  end
      3'b101: begin load_val = {16'h0, ld_half};             load_ok = !off[0];  end
      3'b010: begin load_val = in_load_data;                 load_ok = (off == 2'b00); end
      default: begin load_val = 32'h0;                       load_ok = 1'b0;     end
    endcase
  end

  always_comb begin
    result    = in_alu_result;
    result_wr = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin result = in_alu_result; result_wr = 1'b1; end
      OPC_JAL, OPC_JALR:                      begin result = in_pc + 32'd4; result_wr = 1'b1; end
      OPC_LOAD:                               begin result = load_val;      result_wr = load_ok; end
      default:                                begin result = in_alu_result; result_wr = 1'b0; end
    endcase
  end

  // addr_rd/data_rd follow every accepted instruction; only write_enable qualifies them
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_RUN;
      addr_rd      <= 32'h0;
      data_rd      <= 32'h0;
      write_enable <= 1'b0;
      retire_count <= '0;
      load_error   <= 1'b0;
      halted       <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      if (accept) begin
        addr_rd      <= in_instr;
        data_rd      <= result;
        write_enable <= result_wr && (rd != 5'd0);
        retire_count <= retire_count + RETIRE_W'(1);
        if (is_load && !load_ok)
          load_error <= 1'b1;
        if (HALT_ON_SYSTEM && is_system) begin
          state  <= ST_HALTED;
          halted <= 1'b1;
        end
      end
    end
  end

  assign fwd_valid = write_enable;
  assign fwd_rd    = addr_rd[11:7];
  assign fwd_data  = data_rd;

endmodule
